// File: rtl/lim_dec_timer_if.sv
// Control/status bundle for lim_dec_timer.
// Master side (prescaler / sequencer) drives load, din, start, pause, tick.
// Slave side (the timer) returns count, zero, running, done.
// Digit i of din/count lives at [i*N +: N], digit 0 least significant.
interface lim_dec_timer_if #(
   parameter int L = 10,
   parameter int D = 2,
   parameter int N = $clog2(L)
);
   logic           load;
   logic [D*N-1:0] din;
   logic           start;
   logic           pause;
   logic           tick;
   logic [D*N-1:0] count;
   logic           zero;
   logic           running;
   logic           done;

   modport master (
      output load, din, start, pause, tick,
      input  count, zero, running, done
   );

   modport slave (
      input  load, din, start, pause, tick,
      output count, zero, running, done
   );
endinterface

// File: rtl/lim_dec_timer.sv
// Multi-digit modulo-L countdown timer.
// Loads a (per-digit saturated) value, counts it down by one on each
// unpaused tick while running, borrowing across digits, and stops at
// zero with a one-cycle done pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    lim_dec_timer_if.slave: load/din/start/pause/tick in,
//          count/zero/running/done out
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | count held, waiting for start
// ST_RUN  | decrement on tick && !pause, leave for DONE on reaching 0
// ST_DONE | count held at 0, only load leaves
module lim_dec_timer #(
   parameter int L = 10,
   parameter int D = 2,
   parameter int N = $clog2(L)
) (
   input  logic            clk,
   input  logic            rst_n,
   lim_dec_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] DIG_MAX = N'(L - 1);

   state_t         state_q, state_d;
   logic [D*N-1:0] count_q, count_d;
   logic           done_q, done_d;

   logic [D*N-1:0] count_sat;
   logic [D*N-1:0] count_dec;
   logic           count_is_zero;

   // Out-of-range load digits clamp to L-1 independently per digit.
   always_comb begin
      count_sat = '0;
      for (int i = 0; i < D; i++) begin
         if (bus.din[i*N +: N] > DIG_MAX) begin
            count_sat[i*N +: N] = DIG_MAX;
         end else begin
            count_sat[i*N +: N] = bus.din[i*N +: N];
         end
      end
   end

   // Ripple borrow through the digits; digit 0 always receives a borrow.
   // Only used when count_q != 0, so the top digit never borrows out.
   always_comb begin
      logic          borrow;
      logic [N-1:0]  dig;
      count_dec = '0;
      borrow    = 1'b1;
      dig       = '0;
      for (int i = 0; i < D; i++) begin
         dig = count_q[i*N +: N];
         if (borrow) begin
            if (dig == '0) begin
               count_dec[i*N +: N] = DIG_MAX;
               borrow              = 1'b1;
            end else begin
               count_dec[i*N +: N] = dig - N'(1);
               borrow              = 1'b0;
            end
         end else begin
            count_dec[i*N +: N] = dig;
         end
      end
   end

   assign count_is_zero = (count_q == '0);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (bus.load) begin
         count_d = count_sat;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (count_is_zero) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (bus.tick && !bus.pause) begin
                  count_d = count_dec;
                  if (count_dec == '0) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.zero    = count_is_zero;
   assign bus.running = (state_q == ST_RUN);
   assign bus.done    = done_q;

endmodule

// File: tb/tb_lim_dec_timer.sv
module tb_lim_dec_timer;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   lim_dec_timer_if #(.L(10), .D(2), .N(4)) ifa ();
   lim_dec_timer_if #(.L(6),  .D(3), .N(3)) ifb ();

   lim_dec_timer #(.L(10), .D(2), .N(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );

   lim_dec_timer #(.L(6), .D(3), .N(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock for the L=10/D=2 timer; outputs sampled 1 time unit after the edge.
   task automatic step(input logic ld, input logic [7:0] d, input logic st,
                       input logic ps, input logic tk);
      ifa.load  = ld;
      ifa.din   = d;
      ifa.start = st;
      ifa.pause = ps;
      ifa.tick  = tk;
      @(posedge clk);
      #1;
      ifa.load  = 1'b0;
      ifa.start = 1'b0;
      ifa.pause = 1'b0;
      ifa.tick  = 1'b0;
   endtask

   task automatic step_b(input logic ld, input logic [8:0] d, input logic st,
                         input logic tk);
      ifb.load  = ld;
      ifb.din   = d;
      ifb.start = st;
      ifb.pause = 1'b0;
      ifb.tick  = tk;
      @(posedge clk);
      #1;
      ifb.load  = 1'b0;
      ifb.start = 1'b0;
      ifb.tick  = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #23;
      checks++; if (ifa.count !== 8'h00) begin errs++; $display("FAIL reset_count got=%h exp=00", ifa.count); end
      checks++; if (ifa.zero !== 1'b1) begin errs++; $display("FAIL reset_zero got=%b exp=1", ifa.zero); end
      checks++; if (ifa.running !== 1'b0) begin errs++; $display("FAIL reset_running got=%b exp=0", ifa.running); end
      checks++; if (ifa.done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", ifa.done); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 8'h37, 1'b0, 1'b0, 1'b0);
      checks++; if (ifa.count !== 8'h37) begin errs++; $display("FAIL reset_load37 got=%h exp=37", ifa.count); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.running !== 1'b1) begin errs++; $display("FAIL reset_run37 got=%b exp=1", ifa.running); end
      // asynchronous reset mid-RUN, checked before the next edge
      rst_n = 1'b0;
      #2;
      checks++; if (ifa.count !== 8'h00) begin errs++; $display("FAIL async_count got=%h exp=00", ifa.count); end
      checks++; if (ifa.zero !== 1'b1) begin errs++; $display("FAIL async_zero got=%b exp=1", ifa.zero); end
      checks++; if (ifa.running !== 1'b0) begin errs++; $display("FAIL async_running got=%b exp=0", ifa.running); end
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.done !== 1'b1) begin errs++; $display("FAIL start_zero_done got=%b exp=1", ifa.done); end
      // reset cuts the done pulse short
      rst_n = 1'b0;
      #2;
      checks++; if (ifa.done !== 1'b0) begin errs++; $display("FAIL async_done_cut got=%b exp=0", ifa.done); end
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.done !== 1'b1) begin errs++; $display("FAIL start_zero_done2 got=%b exp=1", ifa.done); end
      checks++; if (ifa.running !== 1'b0) begin errs++; $display("FAIL start_zero_running got=%b exp=0", ifa.running); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (ifa.done !== 1'b0) begin errs++; $display("FAIL done_one_cycle got=%b exp=0", ifa.done); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.done !== 1'b0) begin errs++; $display("FAIL done_restart got=%b exp=0", ifa.done); end
   endtask

   task automatic test_countdown;
      logic [7:0] exp_seq [3];
      exp_seq[0] = 8'h24; exp_seq[1] = 8'h23; exp_seq[2] = 8'h22;
      step(1'b1, 8'h25, 1'b0, 1'b0, 1'b0);
      checks++; if (ifa.running !== 1'b0) begin errs++; $display("FAIL load_idle_running got=%b exp=0", ifa.running); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.running !== 1'b1) begin errs++; $display("FAIL start_running got=%b exp=1", ifa.running); end
      checks++; if (ifa.count !== 8'h25) begin errs++; $display("FAIL start_hold got=%h exp=25", ifa.count); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         checks++; if (ifa.count !== exp_seq[i]) begin errs++; $display("FAIL countdown_%0d got=%h exp=%h", i, ifa.count, exp_seq[i]); end
      end
      step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (ifa.count !== 8'h19) begin errs++; $display("FAIL borrow_20 got=%h exp=19", ifa.count); end
      checks++; if (ifa.running !== 1'b1) begin errs++; $display("FAIL borrow_running got=%b exp=1", ifa.running); end
   endtask

   task automatic test_terminal;
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (ifa.count !== 8'h00) begin errs++; $display("FAIL term_count got=%h exp=00", ifa.count); end
      checks++; if (ifa.zero !== 1'b1) begin errs++; $display("FAIL term_zero got=%b exp=1", ifa.zero); end
      checks++; if (ifa.running !== 1'b0) begin errs++; $display("FAIL term_running got=%b exp=0", ifa.running); end
      checks++; if (ifa.done !== 1'b1) begin errs++; $display("FAIL term_done got=%b exp=1", ifa.done); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (ifa.done !== 1'b0) begin errs++; $display("FAIL term_done_drop got=%b exp=0", ifa.done); end
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         checks++; if (ifa.count !== 8'h00 || ifa.done !== 1'b0) begin errs++; $display("FAIL term_tick_%0d got=%h/%b exp=00/0", i, ifa.count, ifa.done); end
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.count !== 8'h00 || ifa.done !== 1'b0 || ifa.running !== 1'b0) begin errs++; $display("FAIL term_start got=%h/%b/%b exp=00/0/0", ifa.count, ifa.done, ifa.running); end
   endtask

   task automatic test_saturation;
      step(1'b1, 8'hCF, 1'b0, 1'b0, 1'b0);
      checks++; if (ifa.count !== 8'h99) begin errs++; $display("FAIL sat_12_15 got=%h exp=99", ifa.count); end
      step(1'b1, 8'h3B, 1'b0, 1'b0, 1'b0);
      checks++; if (ifa.count !== 8'h39) begin errs++; $display("FAIL sat_3_11 got=%h exp=39", ifa.count); end
   endtask

   task automatic test_priority;
      step(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      end
      checks++; if (ifa.count !== 8'h50) begin errs++; $display("FAIL pause_hold got=%h exp=50", ifa.count); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (ifa.count !== 8'h49) begin errs++; $display("FAIL unpause_tick got=%h exp=49", ifa.count); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.count !== 8'h49 || ifa.running !== 1'b1) begin errs++; $display("FAIL start_in_run got=%h/%b exp=49/1", ifa.count, ifa.running); end
      step(1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
      checks++; if (ifa.count !== 8'h07) begin errs++; $display("FAIL load_tick_count got=%h exp=07", ifa.count); end
      checks++; if (ifa.running !== 1'b0) begin errs++; $display("FAIL load_tick_idle got=%b exp=0", ifa.running); end
      step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
      checks++; if (ifa.count !== 8'h05 || ifa.running !== 1'b0) begin errs++; $display("FAIL load_start got=%h/%b exp=05/0", ifa.count, ifa.running); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (ifa.count !== 8'h05) begin errs++; $display("FAIL idle_tick got=%h exp=05", ifa.count); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_seq [3];
      exp_seq[0] = 8'h11; exp_seq[1] = 8'h10; exp_seq[2] = 8'h09;
      step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         checks++; if (ifa.count !== exp_seq[i]) begin errs++; $display("FAIL b2b_%0d got=%h exp=%h", i, ifa.count, exp_seq[i]); end
      end
   endtask

   task automatic test_wrap;
      step_b(1'b1, 9'b001_000_000, 1'b0, 1'b0);
      checks++; if (ifb.count !== 9'b001_000_000) begin errs++; $display("FAIL wrap_load got=%b exp=001000000", ifb.count); end
      step_b(1'b0, 9'd0, 1'b1, 1'b0);
      step_b(1'b0, 9'd0, 1'b0, 1'b1);
      checks++; if (ifb.count !== 9'b000_101_101) begin errs++; $display("FAIL wrap_055 got=%b exp=000101101", ifb.count); end
      step_b(1'b0, 9'd0, 1'b0, 1'b1);
      checks++; if (ifb.count !== 9'b000_101_100) begin errs++; $display("FAIL wrap_054 got=%b exp=000101100", ifb.count); end
      step_b(1'b1, 9'b111_010_110, 1'b0, 1'b0);
      checks++; if (ifb.count !== 9'b101_010_101) begin errs++; $display("FAIL wrap_sat got=%b exp=101010101", ifb.count); end
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      ifa.load = 1'b0; ifa.din = '0; ifa.start = 1'b0; ifa.pause = 1'b0; ifa.tick = 1'b0;
      ifb.load = 1'b0; ifb.din = '0; ifb.start = 1'b0; ifb.pause = 1'b0; ifb.tick = 1'b0;
      test_reset;
      test_countdown;
      test_terminal;
      test_saturation;
      test_priority;
      test_back_to_back;
      test_wrap;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lim_dec_timer.md
# lim_dec_timer

Multi-digit countdown timer built from cascaded modulo-L digits, the decrementing counterpart of the saturating modulo-L incrementor. It counts a loaded value down by one on each enable tick, borrowing across digits, and stops at zero with a one-cycle completion pulse. It drives the game-time countdown and similar down-counting displays. Each digit is presented as an N-bit field for the 7-segment path.

## Interface
- L, 10, modulus of each digit (digit range 0..L-1), L >= 2
- D, 2, number of digits
- N, $clog2(L), bits per digit
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  load din into count, force state IDLE
- din  input  D*N  load value, digit i at din[i*N +: N], digit 0 least significant
- start  input  1  begin counting, honored in IDLE only
- pause  input  1  while high in RUN, ticks are ignored
- tick  input  1  decrement enable, one-cycle strobe from the prescaler
- count  output  D*N  current value, same digit packing as din
- zero  output  1  count == 0, combinational from the count register
- running  output  1  state == RUN
- done  output  1  one-cycle pulse on entry to DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: count held. start=1 with count != 0 -> RUN. start=1 with count == 0 -> DONE.
- RUN: tick=1 and pause=0 -> decrement. The new value is 0 -> DONE. start is ignored.
- DONE: count held at 0, ticks ignored. start=1 -> stays DONE, with no new done pulse. Only load leaves DONE.
- load is valid in any state and takes priority over start, tick and pause in the same cycle. State -> IDLE.
- Load saturation: each digit with din field > L-1 loads L-1. Fields in range load unchanged.
- Decrement per digit i, with borrow_in(0) = 1:
  - borrow_in=1 and digit=0 -> digit becomes L-1, borrow_out=1.
  - borrow_in=1 and digit>0 -> digit-1, borrow_out=0.
  - borrow_in=0 -> digit unchanged.
- A borrow out of digit D-1 cannot occur, because count == 0 is never decremented.
- Arithmetic is per digit on N bits. No binary carry crosses digit fields.
- done=1 exactly once per entry into DONE. This covers both entry from RUN by tick and entry from IDLE by start at zero.
- Reset values: count=0, state=IDLE, running=0, done=0, so zero=1.

## Timing
- tick, start and load are sampled on the rising edge. count, state, running and done update at that same edge.
- Decrement latency is one edge. Inputs tick=1, pause=0 in cycle k give the new count in cycle k+1.
- done is registered. It is high for the single cycle after the edge that enters DONE, then 0.
- running is high from the cycle after the accepted start until the cycle after the last tick.
- Simultaneous events:
  - load with tick: load wins, no decrement.
  - load with start: load wins, state IDLE.
  - pause with tick: no change.
- A tick held high for consecutive cycles decrements every cycle.
- rst_n low at any time, including mid-RUN or during a done pulse:
  - All registers take their reset values immediately, without waiting for a clock edge.
  - A done pulse in progress is cut short.
  - Operation resumes on the first edge after rst_n returns high.

## Test plan
- Reset: rst_n=0 mid-RUN with count=37 -> count=00, zero=1, running=0, done=0 before the next edge. After release, start at zero -> done pulses once, state DONE.
- Basic countdown (L=10, D=2): load din=25, start, then 3 ticks -> count 24, 23, 22. Continue from count=20, tick -> count=19, the borrow case.
- Terminal: load 01, start, tick -> count=00, zero=1, running=0, done high for exactly 1 cycle. 5 further ticks and a start -> count stays 00, no done.
- Load saturation: din digit1=12, digit0=15 -> count=99. din digit1=3, digit0=11 -> count=39.
- Priority and pause:
  - RUN at 50, pause=1, 4 ticks -> 50 held.
  - pause=0, tick -> 49.
  - load din=07 with tick in the same cycle -> count=07, state IDLE.
  - start during RUN -> no effect.
- Full wrap chain (D=3, L=6): load 100, start, tick -> count=055. Tick -> 054.
